// File: rtl/mpx_bridge_pkg.sv
// Shared types and limits for the multiplexed 16-to-8-bit bus bridge.
package mpx_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WAIT_MAX = 15;

    // Wait counter width: enough for WAIT_CYCLES, never narrower than one bit.
    function automatic int cnt_width(input int wait_cycles);
        if (wait_cycles < 1) return 1;
        return $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mpx_bridge_if.sv
// CPU-side and 8-bit-side signal bundle of the bridge; word data is MSB-first (bit 0 = MSB).
interface mpx_bridge_if;
    logic        clk_en;
    logic        start;
    logic        memen;
    logic        we;
    logic        sysrdy;
    logic [0:15] q;
    logic [0:7]  d8;
    logic        memen8;
    logic        a15;
    logic [0:7]  q8;
    logic [0:15] d;
    logic        ready;

    modport slave (
        input  clk_en, start, memen, we, sysrdy, q, d8,
        output memen8, a15, q8, d, ready
    );

    modport master (
        output clk_en, start, memen, we, sysrdy, q, d8,
        input  memen8, a15, q8, d, ready
    );
endinterface

// File: rtl/mpx_wait_counter.sv
// Loadable down-counter that inserts wait ticks into each 8-bit byte cycle.
module mpx_wait_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            if (load) begin
                count <= load_val;
            end else if (dec && count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mpx_bridge.sv
// Splits a 16-bit CPU access into two 8-bit bus cycles with wait states.
// Optional MPX_BRIDGE_TURBO_EN adds a turbo input that skips the wait ticks.
module mpx_bridge
    import mpx_bridge_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter bit BYTE_FIRST  = 1'b1
) (
    input  logic clk,
    input  logic reset,
`ifdef MPX_BRIDGE_TURBO_EN
    input  logic turbo,
`endif
    mpx_bridge_if.slave bus
);

    localparam int CNT_W = cnt_width(WAIT_CYCLES);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
        $error("mpx_bridge: WAIT_CYCLES out of range");
    end

    state_t           state;
    state_t           state_nxt;
    logic             access_go;
    logic             busy;
    logic             zero;
    logic             byte_done;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] load_val;
    logic             we_r;
    logic [0:15]      d_r;
    logic             memen8;
    logic             a15;
    logic             ready;

    assign access_go = bus.start & bus.memen;
    assign busy      = (state == BYTE1) || (state == BYTE2);
    assign byte_done = busy & bus.memen & zero & bus.sysrdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (bus.clk_en) begin
            state <= state_nxt;
        end
    end

    // Dropping memen mid-access abandons it; dropping it in DONE re-arms the bridge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (access_go) state_nxt = BYTE1;
            BYTE1: if (!bus.memen) state_nxt = IDLE;
                   else if (byte_done) state_nxt = BYTE2;
            BYTE2: if (!bus.memen) state_nxt = IDLE;
                   else if (byte_done) state_nxt = DONE;
            DONE:  if (!bus.memen) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        memen8 = 1'b0;
        a15    = BYTE_FIRST;
        ready  = 1'b1;
        unique case (state)
            IDLE:  ready = ~access_go;
            BYTE1: begin
                memen8 = 1'b1;
                ready  = 1'b0;
            end
            BYTE2: begin
                memen8 = 1'b1;
                ready  = 1'b0;
                a15    = ~BYTE_FIRST;
            end
            DONE:  ready = 1'b1;
            default: ready = 1'b1;
        endcase
    end

    // Counter loads at access start and again at the BYTE1->BYTE2 handover.
    assign cnt_load = ((state == IDLE) && access_go) || ((state == BYTE1) && byte_done);
    assign cnt_dec  = busy & ~zero;

`ifdef MPX_BRIDGE_TURBO_EN
    assign load_val = turbo ? '0 : WAIT_CYCLES[CNT_W-1:0];
`else
    assign load_val = WAIT_CYCLES[CNT_W-1:0];
`endif

    mpx_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.clk_en),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (cnt_dec),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            we_r <= 1'b0;
            d_r  <= '1;
        end else if (bus.clk_en) begin
            if ((state == IDLE) && access_go) we_r <= bus.we;
            if (byte_done && !we_r) begin
                if (a15) d_r[8:15] <= bus.d8;
                else     d_r[0:7]  <= bus.d8;
            end
        end
    end

    assign bus.memen8 = memen8;
    assign bus.a15    = a15;
    assign bus.ready  = ready;
    assign bus.d      = d_r;
    assign bus.q8     = a15 ? bus.q[8:15] : bus.q[0:7];

endmodule

// File: tb/tb_mpx_bridge.sv
// Scoreboard bench: two bridges (WAIT_CYCLES=4 and 0) share stimulus; a monitor checks each access.
module tb_mpx_bridge;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

`ifdef MPX_BRIDGE_TURBO_EN
    logic turbo;
    bit   turbo_sel;
    assign turbo = turbo_sel;
`endif

    mpx_bridge_if bus4 ();
    mpx_bridge_if bus0 ();

    logic [7:0] lo_byte;
    logic [7:0] hi_byte;

    // 8-bit device: returns the low byte of the word when a15=1, high byte when a15=0.
    assign bus4.d8 = bus4.a15 ? lo_byte : hi_byte;
    assign bus0.d8 = bus0.a15 ? lo_byte : hi_byte;

    assign bus0.clk_en = bus4.clk_en;
    assign bus0.start  = bus4.start;
    assign bus0.memen  = bus4.memen;
    assign bus0.we     = bus4.we;
    assign bus0.sysrdy = bus4.sysrdy;
    assign bus0.q      = bus4.q;

    mpx_bridge #(.WAIT_CYCLES(4), .BYTE_FIRST(1'b1)) u_dut4 (
        .clk   (clk),
        .reset (reset),
`ifdef MPX_BRIDGE_TURBO_EN
        .turbo (turbo),
`endif
        .bus   (bus4)
    );

    mpx_bridge #(.WAIT_CYCLES(0), .BYTE_FIRST(1'b1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
`ifdef MPX_BRIDGE_TURBO_EN
        .turbo (turbo),
`endif
        .bus   (bus0)
    );

    typedef struct {
        logic [15:0] d;
        int          ticks;
        bit          chk_q8;
        logic [7:0]  q8a;
        logic [7:0]  q8b;
    } txn_t;

    typedef struct {
        int          kind;
        int          dut;
        bit          use_m8;
        logic        m8;
        bit          use_a;
        logic        a;
        bit          use_d;
        logic [15:0] d;
        bit          use_r;
        logic        r;
    } snap_t;

    txn_t  exp4[$];
    txn_t  exp0[$];
    snap_t snaps[$];

    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut_w%0d actual=%0h required=%0h", nm, (id == 0) ? 4 : 0, act, req);
        end
    endtask

    function automatic txn_t mk(input logic [15:0] d, input int t, input bit c,
                                input logic [7:0] a, input logic [7:0] b);
        txn_t e;
        e.d = d; e.ticks = t; e.chk_q8 = c; e.q8a = a; e.q8b = b;
        return e;
    endfunction

    task automatic push_snap(input int dut, input bit um8, input logic m8, input bit ua, input logic a,
                             input bit ud, input logic [15:0] d, input bit ur, input logic r);
        snap_t s;
        s.kind = 0; s.dut = dut;
        s.use_m8 = um8; s.m8 = m8; s.use_a = ua; s.a = a;
        s.use_d = ud; s.d = d; s.use_r = ur; s.r = r;
        snaps.push_back(s);
    endtask

    // Monitor state, one slot per DUT (0: WAIT_CYCLES=4, 1: WAIT_CYCLES=0).
    bit         in_txn[2];
    int         tk[2];
    logic [7:0] qa[2];
    logic [7:0] qb[2];
    logic       a15a[2];
    bit         got2[2];
    bit         rdy_bad[2];

    task automatic mon_step(input int id, input logic m8, input logic rdy, input logic a,
                            input logic ce, input logic [7:0] qq, input logic [15:0] dd);
        txn_t e;
        int   pending;
        if (m8 === 1'b1) begin
            if (!in_txn[id]) begin
                in_txn[id] = 1; tk[id] = 0; qa[id] = qq; a15a[id] = a;
                got2[id] = 0; rdy_bad[id] = 0;
            end else if (!got2[id] && a !== a15a[id]) begin
                got2[id] = 1; qb[id] = qq;
            end
            if (ce === 1'b1) tk[id]++;
            if (rdy !== 1'b0) rdy_bad[id] = 1;
        end else if (in_txn[id]) begin
            in_txn[id] = 0;
            pending = (id == 0) ? exp4.size() : exp0.size();
            cmp("expected_txn_pending", id, (pending > 0), 1);
            if (pending > 0) begin
                if (id == 0) e = exp4.pop_front();
                else         e = exp0.pop_front();
                cmp("read_word", id, dd, e.d);
                if (e.ticks >= 0) cmp("busy_ticks", id, tk[id], e.ticks);
                cmp("ready_low_while_busy", id, rdy_bad[id], 0);
                if (e.chk_q8) begin
                    cmp("a15_first_byte", id, a15a[id], 1);
                    cmp("q8_first_byte", id, qa[id], e.q8a);
                    cmp("second_byte_seen", id, got2[id], 1);
                    cmp("q8_second_byte", id, qb[id], e.q8b);
                end
            end
        end
    endtask

    snap_t       cur;
    logic        sm8, sa, sr;
    logic [15:0] sd;

    always @(negedge clk) begin
        mon_step(0, bus4.memen8, bus4.ready, bus4.a15, bus4.clk_en, bus4.q8, bus4.d);
        mon_step(1, bus0.memen8, bus0.ready, bus0.a15, bus0.clk_en, bus0.q8, bus0.d);
        while (snaps.size() > 0) begin
            cur = snaps.pop_front();
            if (cur.kind == 1) begin
                cmp("leftover_expectations", 0, exp4.size(), 0);
                cmp("leftover_expectations", 1, exp0.size(), 0);
            end else begin
                if (cur.dut == 0) begin
                    sm8 = bus4.memen8; sa = bus4.a15; sd = bus4.d; sr = bus4.ready;
                end else begin
                    sm8 = bus0.memen8; sa = bus0.a15; sd = bus0.d; sr = bus0.ready;
                end
                if (cur.use_m8) cmp("snap_memen8", cur.dut, sm8, cur.m8);
                if (cur.use_a)  cmp("snap_a15", cur.dut, sa, cur.a);
                if (cur.use_d)  cmp("snap_d", cur.dut, sd, cur.d);
                if (cur.use_r)  cmp("snap_ready", cur.dut, sr, cur.r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access on both DUTs; abort_at/reset_at name the busy tick where memen drops / reset hits.
    task automatic access(input logic w, input logic [15:0] qv, input logic [7:0] lo, input logic [7:0] hi,
                          input txn_t e4, input txn_t e0, input int stall_at, input int stall_n,
                          input bit gate, input int abort_at, input int reset_at);
        bit done;
        lo_byte = lo; hi_byte = hi;
        exp4.push_back(e4);
        exp0.push_back(e0);
        bus4.we = w; bus4.q = qv; bus4.start = 1'b1; bus4.memen = 1'b1;
        bus4.clk_en = 1'b1; bus4.sysrdy = 1'b1;
        push_snap(0, 1, 1'b0, 0, 1'b0, 0, 16'h0, 1, 1'b0);
        push_snap(1, 1, 1'b0, 0, 1'b0, 0, 16'h0, 1, 1'b0);
        tick();
        done = 0;
        for (int k = 1; k <= 200 && !done; k++) begin
            bus4.clk_en = gate ? (k % 2 == 1) : 1'b1;
            bus4.sysrdy = bus4.clk_en && !(k >= stall_at && k < stall_at + stall_n);
            if (k == abort_at) begin bus4.memen = 1'b0; bus4.start = 1'b0; end
            if (k == reset_at) begin reset = 1'b1; bus4.start = 1'b0; end
            tick();
            if (k == abort_at || k == reset_at) done = 1;
            else if (bus4.ready && bus0.ready) done = 1;
            if (k == 200 && !done) begin
                $display("FAIL access_timeout dut ready=%0b/%0b required=1", bus4.ready, bus0.ready);
                $fatal(1);
            end
        end
        bus4.clk_en = 1'b1; bus4.sysrdy = 1'b1;
        if (reset_at > 0) begin
            reset = 1'b0;
            push_snap(0, 1, 1'b0, 1, 1'b1, 1, 16'hFFFF, 1, 1'b1);
            push_snap(1, 1, 1'b0, 0, 1'b0, 1, 16'hFFFF, 0, 1'b0);
            tick();
        end else if (abort_at == 0) begin
            // Hold memen (and start) in DONE: no second access may begin.
            for (int h = 0; h < 2; h++) begin
                push_snap(0, 1, 1'b0, 0, 1'b0, 0, 16'h0, 1, 1'b1);
                push_snap(1, 1, 1'b0, 0, 1'b0, 0, 16'h0, 1, 1'b1);
                tick();
            end
        end
        bus4.start = 1'b0; bus4.memen = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus4.clk_en = 1'b0; bus4.start = 1'b0; bus4.memen = 1'b0; bus4.we = 1'b0;
        bus4.sysrdy = 1'b0; bus4.q = 16'h0;
        lo_byte = 8'h00; hi_byte = 8'h00;
`ifdef MPX_BRIDGE_TURBO_EN
        turbo_sel = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b0;
        push_snap(0, 1, 1'b0, 1, 1'b1, 1, 16'hFFFF, 1, 1'b1);
        push_snap(1, 1, 1'b0, 1, 1'b1, 1, 16'hFFFF, 1, 1'b1);
        tick();

        // Write 16'hABCD: low byte CD first (a15=1), then AB; d keeps its reset value.
        access(1'b1, 16'hABCD, 8'h55, 8'h66,
               mk(16'hFFFF, 10, 1, 8'hCD, 8'hAB), mk(16'hFFFF, 2, 1, 8'hCD, 8'hAB), 0, 0, 0, 0, 0);
        // Read: 34 on the a15=1 byte, 12 on the a15=0 byte.
        access(1'b0, 16'h0000, 8'h34, 8'h12,
               mk(16'h1234, 10, 0, 8'h0, 8'h0), mk(16'h1234, 2, 0, 8'h0, 8'h0), 0, 0, 0, 0, 0);
        // sysrdy low for three ticks once BYTE2 has counted down (ticks 10..12).
        access(1'b0, 16'h0000, 8'h78, 8'h56,
               mk(16'h5678, 13, 0, 8'h0, 8'h0), mk(16'h5678, 2, 0, 8'h0, 8'h0), 10, 3, 0, 0, 0);
        // clk_en every other cycle, sysrdy low on the disabled cycles.
        access(1'b0, 16'h0000, 8'hBC, 8'h9A,
               mk(16'h9ABC, 10, 0, 8'h0, 8'h0), mk(16'h9ABC, 2, 0, 8'h0, 8'h0), 0, 0, 1, 0, 0);
        // memen dropped on busy tick 3: wide-wait bridge aborts with d untouched.
        access(1'b0, 16'h0000, 8'h11, 8'h22,
               mk(16'h9ABC, 3, 0, 8'h0, 8'h0), mk(16'h2211, 2, 0, 8'h0, 8'h0), 0, 0, 0, 3, 0);
        // Reset on busy tick 3 (mid BYTE1 for the wide-wait bridge).
        access(1'b0, 16'h0000, 8'h33, 8'h44,
               mk(16'hFFFF, 3, 0, 8'h0, 8'h0), mk(16'h4433, 2, 0, 8'h0, 8'h0), 0, 0, 0, 0, 3);
        access(1'b0, 16'h0000, 8'hEF, 8'hCD,
               mk(16'hCDEF, 10, 0, 8'h0, 8'h0), mk(16'hCDEF, 2, 0, 8'h0, 8'h0), 0, 0, 0, 0, 0);
`ifdef MPX_BRIDGE_TURBO_EN
        turbo_sel = 1'b1;
        access(1'b0, 16'h0000, 8'h01, 8'h02,
               mk(16'h0201, 2, 0, 8'h0, 8'h0), mk(16'h0201, 2, 0, 8'h0, 8'h0), 0, 0, 0, 0, 0);
        turbo_sel = 1'b0;
        access(1'b0, 16'h0000, 8'h03, 8'h04,
               mk(16'h0403, 10, 0, 8'h0, 8'h0), mk(16'h0403, 2, 0, 8'h0, 8'h0), 0, 0, 0, 0, 0);
`endif

        cur.kind = 1; cur.dut = 0;
        cur.use_m8 = 0; cur.m8 = 1'b0; cur.use_a = 0; cur.a = 1'b0;
        cur.use_d = 0; cur.d = 16'h0; cur.use_r = 0; cur.r = 1'b0;
        snaps.push_back(cur);
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
